// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// mux encodings and the register-match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StError   = 2'b10
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational dependency detection: ID-stage stall request and EX operand
// forwarding selects. Behaviour depends on the FORWARDING_EN macro.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] ars1_id,
    input  logic [4:0] ars2_id,
    input  logic [4:0] ars1_ex,
    input  logic [4:0] ars2_ex,
    input  logic [4:0] ard_ex,
    input  logic       regwrite_ex,
    input  logic       memtoreg_ex,
    input  logic [4:0] ard_mem,
    input  logic       regwrite_mem,
    input  logic [4:0] ard_wb,
    input  logic       regwrite_wb,
    output logic       id_stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic ex_hit_id;
    logic mem_hit_id;

    assign ex_hit_id  = reg_match(regwrite_ex, ard_ex, ars1_id) ||
                        reg_match(regwrite_ex, ard_ex, ars2_id);
    assign mem_hit_id = reg_match(regwrite_mem, ard_mem, ars1_id) ||
                        reg_match(regwrite_mem, ard_mem, ars2_id);

`ifdef FORWARDING_EN
    // Only a load result is too late to forward into the following instruction.
    assign id_stall = memtoreg_ex && ex_hit_id;

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (reg_match(regwrite_mem, ard_mem, ars1_ex)) begin
            fwd_a = FWD_MEM;
        end else if (reg_match(regwrite_wb, ard_wb, ars1_ex)) begin
            fwd_a = FWD_WB;
        end
        if (reg_match(regwrite_mem, ard_mem, ars2_ex)) begin
            fwd_b = FWD_MEM;
        end else if (reg_match(regwrite_wb, ard_wb, ars2_ex)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    // Without bypass paths, wait until the producer reaches WB; the regfile
    // writes before it reads, so a WB-stage producer needs no stall.
    logic unused_inputs;

    assign id_stall      = ex_hit_id || mem_hit_id;
    assign fwd_a         = FWD_REG;
    assign fwd_b         = FWD_REG;
    assign unused_inputs = ^{ars1_ex, ars2_ex, ard_wb, regwrite_wb, memtoreg_ex};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// memory-wait stalls with timeout. Optional bypassing via FORWARDING_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ars1_id,
    input  logic [4:0]       ars2_id,
    input  logic [4:0]       ars1_ex,
    input  logic [4:0]       ars2_ex,
    input  logic [4:0]       ard_ex,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic [4:0]       ard_mem,
    input  logic             regwrite_mem,
    input  logic             memwrite_mem,
    input  logic             memtoreg_mem,
    input  logic [4:0]       ard_wb,
    input  logic             regwrite_wb,
    input  logic             branch_taken_ex,
    input  logic             mem_ready,
    output logic             en_pc,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d, wait_next;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             id_stall;
    logic [1:0]       hd_fwd_a, hd_fwd_b;
    logic             mem_busy;
    logic             en_all;
    logic             hold_front;

    hazard_detect u_hazard_detect (
        .ars1_id      (ars1_id),
        .ars2_id      (ars2_id),
        .ars1_ex      (ars1_ex),
        .ars2_ex      (ars2_ex),
        .ard_ex       (ard_ex),
        .regwrite_ex  (regwrite_ex),
        .memtoreg_ex  (memtoreg_ex),
        .ard_mem      (ard_mem),
        .regwrite_mem (regwrite_mem),
        .ard_wb       (ard_wb),
        .regwrite_wb  (regwrite_wb),
        .id_stall     (id_stall),
        .fwd_a        (hd_fwd_a),
        .fwd_b        (hd_fwd_b)
    );

    assign mem_busy  = (memwrite_mem || memtoreg_mem) && !mem_ready;
    assign wait_next = wait_cnt_q + WaitW'(1);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        en_all      = 1'b1;
        hold_front  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        fwd_a       = hd_fwd_a;
        fwd_b       = hd_fwd_b;
        err         = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    en_all     = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StMemWait;
                end else if (branch_taken_ex) begin
                    // The wrong-path instructions are squashed, so any load-use
                    // dependency they carry is irrelevant.
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (id_stall) begin
                    hold_front  = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                end else begin
                    en_all     = 1'b0;
                    wait_cnt_d = wait_next;
                    if (wait_next >= WaitW'(WAIT_TIMEOUT)) begin
                        state_d = StError;
                    end
                end
            end
            StError: begin
                en_all = 1'b0;
                err    = 1'b1;
                fwd_a  = FWD_REG;
                fwd_b  = FWD_REG;
            end
            default: begin
                en_all  = 1'b0;
                state_d = StRun;
            end
        endcase

        // Freeze the whole pipe while reset is held.
        if (!rst) begin
            en_all      = 1'b0;
            hold_front  = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
            fwd_a       = FWD_REG;
            fwd_b       = FWD_REG;
            err         = 1'b0;
        end

        en_pc     = en_all && !hold_front;
        en_if_id  = en_all && !hold_front;
        en_id_ex  = en_all;
        en_ex_mem = en_all;
        en_mem_wb = en_all;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!en_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations follow the
// FORWARDING_EN macro when it is defined for the build.
module tb_pipe_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ars1_id, ars2_id, ars1_ex, ars2_ex, ard_ex, ard_mem, ard_wb;
    logic        regwrite_ex, memtoreg_ex, regwrite_mem, memwrite_mem, memtoreg_mem;
    logic        regwrite_wb, branch_taken_ex, mem_ready;
    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, flush_id_ex, err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    int exp_stall;

    pipe_hazard_ctrl #(
        .WAIT_TIMEOUT (15),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ars1_id         (ars1_id),
        .ars2_id         (ars2_id),
        .ars1_ex         (ars1_ex),
        .ars2_ex         (ars2_ex),
        .ard_ex          (ard_ex),
        .regwrite_ex     (regwrite_ex),
        .memtoreg_ex     (memtoreg_ex),
        .ard_mem         (ard_mem),
        .regwrite_mem    (regwrite_mem),
        .memwrite_mem    (memwrite_mem),
        .memtoreg_mem    (memtoreg_mem),
        .ard_wb          (ard_wb),
        .regwrite_wb     (regwrite_wb),
        .branch_taken_ex (branch_taken_ex),
        .mem_ready       (mem_ready),
        .en_pc           (en_pc),
        .en_if_id        (en_if_id),
        .en_id_ex        (en_id_ex),
        .en_ex_mem       (en_ex_mem),
        .en_mem_wb       (en_mem_wb),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .err             (err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ars1_id = 0; ars2_id = 0; ars1_ex = 0; ars2_ex = 0;
        ard_ex = 0; regwrite_ex = 0; memtoreg_ex = 0;
        ard_mem = 0; regwrite_mem = 0; memwrite_mem = 0; memtoreg_mem = 0;
        ard_wb = 0; regwrite_wb = 0; branch_taken_ex = 0; mem_ready = 1;
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        sample();
        check("rst_en_pc", en_pc, 0);
        check("rst_en_mem_wb", en_mem_wb, 0);
        check("rst_flush", {flush_if_id, flush_id_ex}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_err", err, 0);
        tick();
        rst = 1'b1;

        // Idle pipeline
        sample();
        check("idle_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b11111);
        check("idle_flush", {flush_if_id, flush_id_ex}, 0);
        check("idle_stall_cnt", stall_cnt, 0);
        tick();

        // Load-use on rs1
        ard_ex = 5; regwrite_ex = 1; memtoreg_ex = 1; ars1_id = 5;
        sample();
        check("lu_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b00111);
        check("lu_flush", {flush_if_id, flush_id_ex}, 2'b01);
        check("lu_stall_cnt0", stall_cnt, 0);
        tick();

        // Branch overrides load-use
        branch_taken_ex = 1;
        sample();
        check("lu_stall_cnt1", stall_cnt, 1);
        check("br_flush", {flush_if_id, flush_id_ex}, 2'b11);
        check("br_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b11111);
        tick();

        // Register 0 never matches
        branch_taken_ex = 0; ard_ex = 0; ars1_id = 0;
        sample();
        check("r0_stall_cnt", stall_cnt, 1);
        check("r0_en_pc", en_pc, 1);
        check("r0_flush_id_ex", flush_id_ex, 0);
        check("r0_fwd", {fwd_a, fwd_b}, 0);
        tick();

        // EX/MEM producer vs ID rs2: stalls only without forwarding
        clear_inputs();
        ard_mem = 9; regwrite_mem = 1; ars2_id = 9;
        sample();
        check("mem_id_en_pc", en_pc, Fwd ? 1 : 0);
        check("mem_id_flush_id_ex", flush_id_ex, Fwd ? 0 : 1);
        tick();
        exp_stall = Fwd ? 1 : 2;

        // MEM/WB producer never stalls; forwarded into EX rs1 when enabled
        clear_inputs();
        ard_wb = 3; regwrite_wb = 1; ars1_id = 3; ars1_ex = 3;
        sample();
        check("wb_id_en_pc", en_pc, 1);
        check("wb_fwd_a", fwd_a, Fwd ? 2'b01 : 2'b00);
        check("wb_stall_cnt", stall_cnt, exp_stall);
        tick();

        // EX/MEM takes priority over MEM/WB
        clear_inputs();
        ard_mem = 7; ard_wb = 7; regwrite_mem = 1; regwrite_wb = 1; ars2_ex = 7;
        sample();
        check("fwd_b_mem", fwd_b, Fwd ? 2'b10 : 2'b00);
        check("fwd_b_mem_en", en_pc, 1);
        ard_mem = 0;
        #1;
        check("fwd_b_wb", fwd_b, Fwd ? 2'b01 : 2'b00);
        tick();

        // Memory wait: ready low for 3 cycles, then high
        clear_inputs();
        memtoreg_mem = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("mw_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 0);
            check("mw_flush", {flush_if_id, flush_id_ex}, 0);
            tick();
        end
        mem_ready = 1;
        sample();
        check("mw_done_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b11111);
        tick();
        memtoreg_mem = 0;
        exp_stall += 3;
        sample();
        check("mw_run_en_pc", en_pc, 1);
        check("mw_stall_cnt", stall_cnt, exp_stall);
        tick();

        // Timeout: one RUN cycle entering the wait, then 15 wait cycles
        memwrite_mem = 1; mem_ready = 0;
        ard_mem = 7; regwrite_mem = 1; ars1_ex = 7;
        for (int i = 0; i < 16; i++) begin
            sample();
            check("to_pre_err", err, 0);
            check("to_pre_en_pc", en_pc, 0);
            tick();
        end
        exp_stall += 16;
        mem_ready = 1;
        sample();
        check("to_err", err, 1);
        check("to_err_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 0);
        check("to_err_fwd", fwd_a, 0);
        check("to_stall_cnt", stall_cnt, exp_stall);
        tick();
        sample();
        check("to_err_sticky", err, 1);

        // Reset out of ERROR
        rst = 1'b0;
        #1;
        check("rst2_err", err, 0);
        check("rst2_en_pc", en_pc, 0);
        check("rst2_fwd", fwd_a, 0);
        check("rst2_stall_cnt", stall_cnt, 0);
        tick();
        rst = 1'b1;
        clear_inputs();
        sample();
        check("rst2_run_en", {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 5'b11111);
        check("rst2_run_err", err, 0);
        memtoreg_mem = 1; mem_ready = 0;
        #1;
        check("rst2_run_mw", en_pc, 0);
        tick();
        mem_ready = 1;
        sample();
        check("rst2_mw_release", en_pc, 1);
        check("rst2_stall_cnt1", stall_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 15: maximum consecutive MEM_WAIT cycles before error.
REQ-002 Parameter CNT_W, default 16: STALL_CNT width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ARS1_ID, ARS2_ID  in  5 each  source registers of instruction in ID.
REQ-006 ARS1_EX, ARS2_EX  in  5 each  source registers of instruction in EX.
REQ-007 ARD_EX, REGWRITE_EX, MEMTOREG_EX  in  5/1/1  ID/EX destination and controls.
REQ-008 ARD_MEM, REGWRITE_MEM, MEMWRITE_MEM, MEMTOREG_MEM  in  5/1/1/1  EX/MEM destination and controls.
REQ-009 ARD_WB, REGWRITE_WB  in  5/1  MEM/WB destination and write enable.
REQ-010 BRANCH_TAKEN_EX  in  1  taken branch/jump resolved in EX.
REQ-011 MEM_READY  in  1  data memory completes current access.
REQ-012 EN_PC, EN_IF_ID, EN_ID_EX, EN_EX_MEM, EN_MEM_WB  out  1 each  register load enables.
REQ-013 FLUSH_IF_ID, FLUSH_ID_EX  out  1 each  synchronous bubble insert into that pipe register.
REQ-014 FWD_A, FWD_B  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-015 ERR  out  1  memory timeout, sticky.
REQ-016 STALL_CNT  out  CNT_W  count of cycles with EN_PC low.

Function
REQ-017 FSM states RUN, MEM_WAIT, ERROR; outputs combinational from state and inputs.
REQ-018 Hazard match: REGWRITE set, ARD nonzero, ARD equals source register; register 0 never matches.
REQ-019 RUN, priority 1: (MEMWRITE_MEM or MEMTOREG_MEM) and MEM_READY low -> all EN low same cycle, next state MEM_WAIT.
REQ-020 RUN, priority 2: BRANCH_TAKEN_EX -> FLUSH_IF_ID=1, FLUSH_ID_EX=1, all EN high; load-use stall suppressed.
REQ-021 RUN, priority 3: load-use (MEMTOREG_EX, ID/EX match on ARS1_ID or ARS2_ID) -> EN_PC=0, EN_IF_ID=0, FLUSH_ID_EX=1, others high.
REQ-022 MEM_WAIT: all EN low, no flush; MEM_READY high -> all EN high that cycle, next RUN.
REQ-023 MEM_WAIT: wait counter increments each cycle; reaching WAIT_TIMEOUT with MEM_READY low -> ERROR.
REQ-024 ERROR: all EN low, ERR=1, FWD 00; exit only by reset.
REQ-025 STALL_CNT increments each cycle EN_PC low, saturates at all-ones.
REQ-026 Wait counter clears on every entry to MEM_WAIT.

Reset
REQ-027 rst low: state RUN, wait counter 0, STALL_CNT 0, ERR 0, all EN low, FLUSH 0, FWD 00.
REQ-028 Reset mid-MEM_WAIT or ERROR returns to RUN immediately; first cycle after release behaves as RUN.

Configuration
REQ-029 FORWARDING_EN defined: FWD_A/FWD_B from EX/MEM match (10, priority) else MEM/WB match (01) else 00; stalls only per REQ-021.
REQ-030 FORWARDING_EN undefined: FWD outputs tied 00; any ID source match against ID/EX or EX/MEM stalls per REQ-021 actions; MEM/WB match never stalls (regfile write-before-read).

Structure
REQ-031 Shared package pipe_pkg: state enum, FWD encodings (FWD_REG, FWD_WB, FWD_MEM).
REQ-032 Sub-module hazard_detect: combinational match logic, instantiated once.

Verification
REQ-033 ARD_EX=5, MEMTOREG_EX=1, REGWRITE_EX=1, ARS1_ID=5 -> EN_PC=0, EN_IF_ID=0, FLUSH_ID_EX=1, STALL_CNT 0->1.
REQ-034 Same plus BRANCH_TAKEN_EX=1 -> both flushes 1, EN_PC=1, no stall.
REQ-035 MEMTOREG_MEM=1, MEM_READY low 3 cycles then high -> EN low 3 cycles, RUN on fourth, STALL_CNT=3.
REQ-036 MEM_READY low 16 cycles -> ERR=1 after cycle 15; rst pulse low -> ERR=0, state RUN.
REQ-037 FORWARDING_EN: ARD_MEM=ARD_WB=7, both REGWRITE, ARS2_EX=7 -> FWD_B=10; ARD_MEM=0 -> FWD_B=01.
REQ-038 ARD_EX=0, REGWRITE_EX=1, MEMTOREG_EX=1, ARS1_ID=0 -> no stall, FWD 00.
